cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of functional-unit result sources competing for the CDB (range 1..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 Port: branch_mispredict  input  1  pipeline flush; drops any pending broadcast.
REQ-005 Port: fu_done  input  NUM_REQ  per-source result-valid; held high until acked.
REQ-006 Port: fu_data  input  NUM_REQ x fu_cdb_data_t  per-source result payload; stable while fu_done is high.
REQ-007 Port: cdb_ack  output  NUM_REQ  one-hot-or-zero grant; source i drops fu_done the cycle after cdb_ack[i].
REQ-008 Port: cdb_valid  output  1  registered broadcast-valid.
REQ-009 Port: cdb_data  output  fu_cdb_data_t  registered broadcast payload.
REQ-010 Port: cdb_src  output  $clog2(NUM_REQ) (min 1)  index of source broadcast this cycle.

Function
REQ-011 cdb_ack SHALL be combinational from fu_done, the priority pointer, branch_mispredict and rst, with at most one bit set per cycle.
REQ-012 If any fu_done bit is high, branch_mispredict is low and rst is high, exactly one cdb_ack bit SHALL assert, for a requesting source.
REQ-013 Round-robin: the granted source SHALL be the first requester at or after index ptr, scanning upward modulo NUM_REQ.
REQ-014 After a grant to source g, ptr SHALL become (g+1) mod NUM_REQ on the next edge; with no grant, ptr SHALL hold.
REQ-015 On the edge ending a grant cycle, the arbiter SHALL load fu_data[g] into cdb_data, set cdb_src=g and set cdb_valid=1; latency from grant to broadcast is exactly 1 cycle.
REQ-016 On an edge with no grant, cdb_valid SHALL go to 0; cdb_data and cdb_src SHALL hold their previous values.
REQ-017 A source granted in cycle t that re-asserts fu_done in t+1 or later with a new result SHALL be arbitrated as a fresh request.
REQ-018 In a cycle with branch_mispredict high, cdb_ack SHALL be all zero, and cdb_valid SHALL be 0 on the following edge; ptr SHALL hold.
REQ-019 With all NUM_REQ sources requesting continuously, each source SHALL be granted exactly once in every NUM_REQ consecutive grants.
REQ-020 With NUM_REQ=1, a single requester SHALL be granted every cycle fu_done is high, and ptr SHALL stay 0.

Reset
REQ-021 While rst is low at an edge: cdb_valid<=0, cdb_data<=0, cdb_src<=0, ptr<=0.
REQ-022 While rst is low, cdb_ack SHALL be all zero regardless of fu_done.
REQ-023 A request pending when rst asserts SHALL NOT be broadcast; the first grant after rst releases follows REQ-013 with ptr=0.

Configuration
REQ-024 Macro CDB_ARB_RR_EN defined: ptr and its update SHALL be implemented, giving round-robin per REQ-013/014/019.
REQ-025 Macro CDB_ARB_RR_EN undefined: there SHALL be no ptr register, and priority SHALL be fixed with the lowest index winning; REQ-019 does not apply.

Verification
REQ-026 NUM_REQ=4, RR on, reset, then fu_done=4'b1111 held (each FU re-raises done after ack) -> acks 0001,0010,0100,1000,0001 on consecutive cycles; cdb_src 0,1,2,3,0 one cycle later.
REQ-027 fu_done=4'b0100 for 1 cycle, fu_data[2].value=32'hDEADBEEF -> cdb_ack=4'b0100 same cycle; next cycle cdb_valid=1, cdb_src=2, cdb_data value 32'hDEADBEEF; cycle after cdb_valid=0.
REQ-028 Source 3 granted (ptr=0), then fu_done=4'b1001 -> source 0 granted next.
REQ-029 fu_done=4'b0011 with branch_mispredict=1 for 1 cycle -> cdb_ack=0, cdb_valid=0 next cycle; after flush, fu_done=4'b0011 -> grant source at/after unchanged ptr.
REQ-030 Grant to source 1, then rst low in the broadcast cycle -> cdb_valid=0, ptr=0 after that edge; with CDB_ARB_RR_EN undefined, fu_done=4'b1010 held -> source 1 granted every cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one finished functional unit per cycle and broadcasts its result on the CDB.
// Define CDB_ARB_RR_EN for round-robin priority; leave it undefined for fixed lowest-index-wins priority.
package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } fu_cdb_data_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         branch_mispredict,
    input  logic [NUM_REQ-1:0]           fu_done,
    input  fu_cdb_data_t [NUM_REQ-1:0]   fu_data,
    output logic [NUM_REQ-1:0]           cdb_ack,
    output logic                         cdb_valid,
    output fu_cdb_data_t                 cdb_data,
    output logic [SW-1:0]                cdb_src
);
    logic                r_valid;
    fu_cdb_data_t        r_data;
    logic [SW-1:0]       r_src;
    logic [SW-1:0]       w_base;
    logic [SW-1:0]       w_idx;
    logic [SW-1:0]       w_g;
    logic                w_en;

`ifdef CDB_ARB_RR_EN
    logic [SW-1:0] r_ptr;
    assign w_base = r_ptr;
    always_ff @(posedge clk) begin
        if (!rst)
            r_ptr <= '0;
        else if (w_en)
            r_ptr <= (w_g == SW'(NUM_REQ - 1)) ? '0 : w_g + 1'b1;
    end
`else
    assign w_base = '0;
`endif

    // Scan downward so the requester nearest to w_base is the last one written.
    always_comb begin
        w_idx = '0;
        w_g   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = SW'((int'(w_base) + k) % NUM_REQ);
            if (fu_done[w_idx]) w_g = w_idx;
        end
    end

    assign w_en    = rst & ~branch_mispredict & (|fu_done);
    assign cdb_ack = w_en ? (NUM_REQ'(1) << w_g) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else begin
            r_valid <= w_en;
            if (w_en) begin
                r_data <= fu_data[w_g];
                r_src  <= w_g;
            end
        end
    end

    assign cdb_valid = r_valid;
    assign cdb_data  = r_data;
    assign cdb_src   = r_src;
endmodule
